// File: rtl/mux_scan_ctrl.sv
// Scan controller for the 31:1 selector: walks sel_o over every input, packs the selector
// output into a snapshot and presents it on a valid/ready handshake.
module mux_scan_ctrl #(
    parameter int unsigned NUM_INPUTS = 31,
    parameter int unsigned SEL_W      = 5,
    parameter int unsigned DATA_W     = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    output logic [SEL_W-1:0]             sel_o,
    input  logic [DATA_W-1:0]            mux_out_i,
    output logic [NUM_INPUTS*DATA_W-1:0] snap_data,
    output logic                         snap_valid,
    input  logic                         snap_ready,
    output logic                         busy,
    output logic [7:0]                   scan_cnt
);

    localparam int unsigned SnapW = NUM_INPUTS * DATA_W;
    localparam logic [SEL_W-1:0] LastIdx = SEL_W'(NUM_INPUTS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StHold
    } state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SnapW-1:0]   snap_q, snap_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic [7:0]         cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        snap_d  = snap_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                sel_d   = '0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    state_d = StScan;
                    busy_d  = 1'b1;
                end
            end
            StScan: begin
                for (int i = 0; i < NUM_INPUTS; i++) begin
                    if (sel_q == SEL_W'(i)) begin
                        snap_d[i*DATA_W +: DATA_W] = mux_out_i;
                    end
                end
                // The last capture returns sel to 0 so the unused index is never driven.
                if (sel_q == LastIdx) begin
                    state_d = StHold;
                    sel_d   = '0;
                    valid_d = 1'b1;
                end else begin
                    sel_d = sel_q + 1'b1;
                end
            end
            StHold: begin
                if (snap_ready) begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
                sel_d   = '0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            sel_q   <= '0;
            snap_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            snap_q  <= snap_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sel_o      = sel_q;
    assign snap_data  = snap_q;
    assign snap_valid = valid_q;
    assign busy       = busy_q;
    assign scan_cnt   = cnt_q;

endmodule
